// File: rtl/icache_controller_if.sv
// Fetch-stage and instruction-memory signals of icache_controller.
// HIT_COUNT/MISS_COUNT exist only when ICACHE_PERF_CNT_EN is defined.
interface icache_controller_if;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  // cache side
  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
`ifdef ICACHE_PERF_CNT_EN
    output HIT_COUNT, MISS_COUNT,
`endif
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  // fetch stage + instruction memory side
  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
`ifdef ICACHE_PERF_CNT_EN
    input  HIT_COUNT, MISS_COUNT,
`endif
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped read-only I-cache; hit returns the word combinationally (0 cycles), miss stalls k+2 cycles.
// Backpressure: BUSYWAIT holds PC while the line is fetched; MEM_BUSYWAIT stretches the MEM_READ state.
// Optional hit/miss counters: ICACHE_PERF_CNT_EN.
module icache_controller #(
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_WORDS = 4
) (
  input logic                CLK,
  input logic                RESET,
  icache_controller_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 28 - IDX_W;
  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int LINE_W = 32 * BLOCK_WORDS;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_READ = 2'd1;
  localparam logic [1:0] S_UPDATE   = 2'd2;

  logic [1:0]           state;
  logic [27:0]          blk_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill_en;
  logic [31:0]      word;
  logic             unused_pc_lsb;

  assign pc_off   = bus.PC[2 +: OFF_W];
  assign pc_idx   = bus.PC[4 +: IDX_W];
  assign pc_tag   = bus.PC[31 -: TAG_W];
  assign fill_idx = blk_q[IDX_W-1:0];
  assign fill_tag = blk_q[27 -: TAG_W];
  assign unused_pc_lsb = &{1'b0, bus.PC[1:0]};

  assign hit     = (state == S_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign fill_en = (state == S_MEM_READ) && !bus.MEM_BUSYWAIT;
  assign word    = data_q[pc_idx][pc_off*32 +: 32];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      blk_q   <= '0;
      valid_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!hit) begin
            blk_q <= bus.PC[31:4];
            state <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            state             <= S_UPDATE;
          end
        end
        S_UPDATE: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Fill from the latched address so a PC change mid-miss cannot redirect it.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.MEM_READDATA;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.HIT_COUNT  = hit_cnt;
  assign bus.MISS_COUNT = miss_cnt;
`endif

  // Reset forces a clean NOP/no-stall view even though IDLE with no valid lines would miss.
  always_comb begin
    bus.INSTRUCTION = RESET ? word : NOP;
    bus.BUSYWAIT    = RESET && ((state != S_IDLE) || !hit);
    bus.MEM_READ    = RESET && (state == S_MEM_READ);
    bus.MEM_ADDRESS = (state == S_MEM_READ) ? blk_q : 28'd0;
  end
endmodule
